// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transceiver: parity modes,
// per-direction FSM state encodings and small elaboration/parity helpers.
package uart_pkg;

  localparam int PAR_NONE = 32'sd0;
  localparam int PAR_ODD  = 32'sd1;
  localparam int PAR_EVEN = 32'sd2;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Bit period in clocks, truncated.
  function automatic int div_calc(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Parity bit for a word zero-extended to 16 bits (zero bits do not change XOR).
  function automatic logic par_calc(input logic [15:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PAR_ODD) begin
      return ~p;
    end else if (mode == PAR_EVEN) begin
      return p;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter. A load selects either a full bit period or the
// half period used to land on the middle of a start bit; tick is high while
// the counter sits at zero with the timer enabled.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int DIV        = 10,
  parameter int HALF_START = DIV / 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic half,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] FULL_VAL = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_VAL = CW'(HALF_START - 1);

  logic [CW-1:0] cnt_r;

  // Reload on request, otherwise count down while enabled and rest at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      cnt_r <= half ? HALF_VAL : FULL_VAL;
    end else if (en && (cnt_r != {CW{1'b0}})) begin
      cnt_r <= cnt_r - CW'(1);
    end
  end

  assign tick = en && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/uart_xcvr.sv
// Full-duplex UART transceiver with configurable data width, bit period,
// parity mode and stop-bit count. TX takes words over a valid/ready
// handshake; RX reports each frame with a one-cycle pulse plus error flags.
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_vld,
  output logic              tx_rdy,
  output logic              tx,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_vld,
  output logic              rx_perr,
  output logic              rx_ferr
);

  localparam int DIV = div_calc(CLK_FREQ, BAUD);
  localparam int BCW = $clog2(DATA_W + 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_W - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);
  localparam logic HAS_PAR = (PARITY != PAR_NONE);

  // ---------------------------------------------------------------- TX
  tx_state_e         tx_state_r;
  logic [DATA_W-1:0] tx_shift_r;
  logic [BCW-1:0]    tx_cnt_r;
  logic              tx_par_r;
  logic              tx_r;
  logic              tx_rdy_r;
  logic              tx_go_s;
  logic              tx_tick_s;

  assign tx_go_s = (tx_state_r == TX_IDLE) && tx_vld && tx_rdy_r;

  uart_bit_timer #(.DIV(DIV), .HALF_START(DIV / 2)) u_tx_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (tx_go_s || tx_tick_s),
    .half  (1'b0),
    .en    (tx_state_r != TX_IDLE),
    .tick  (tx_tick_s)
  );

  // TX frame sequencer: each state holds its line level until the bit timer ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_r <= TX_IDLE;
      tx_shift_r <= {DATA_W{1'b0}};
      tx_cnt_r   <= {BCW{1'b0}};
      tx_par_r   <= 1'b0;
      tx_r       <= 1'b1;
      tx_rdy_r   <= 1'b1;
    end else begin
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_go_s) begin
            tx_shift_r <= tx_data;
            tx_par_r   <= par_calc(16'(tx_data), PARITY);
            tx_r       <= 1'b0;
            tx_rdy_r   <= 1'b0;
            tx_state_r <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick_s) begin
            tx_r       <= tx_shift_r[0];
            tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
            tx_cnt_r   <= {BCW{1'b0}};
            tx_state_r <= TX_DATA;
          end
        end
        TX_DATA: begin
          if (tx_tick_s) begin
            if (tx_cnt_r == LAST_BIT) begin
              tx_cnt_r <= {BCW{1'b0}};
              if (HAS_PAR) begin
                tx_r       <= tx_par_r;
                tx_state_r <= TX_PARITY;
              end else begin
                tx_r       <= 1'b1;
                tx_state_r <= TX_STOP;
              end
            end else begin
              tx_r       <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_W-1:1]};
              tx_cnt_r   <= tx_cnt_r + BCW'(1);
            end
          end
        end
        TX_PARITY: begin
          if (tx_tick_s) begin
            tx_r       <= 1'b1;
            tx_cnt_r   <= {BCW{1'b0}};
            tx_state_r <= TX_STOP;
          end
        end
        TX_STOP: begin
          if (tx_tick_s) begin
            if (tx_cnt_r == LAST_STOP) begin
              tx_rdy_r   <= 1'b1;
              tx_state_r <= TX_IDLE;
            end else begin
              tx_cnt_r <= tx_cnt_r + BCW'(1);
            end
          end
        end
        default: begin
          tx_r       <= 1'b1;
          tx_rdy_r   <= 1'b1;
          tx_state_r <= TX_IDLE;
        end
      endcase
    end
  end

  assign tx     = tx_r;
  assign tx_rdy = tx_rdy_r;

  // ---------------------------------------------------------------- RX
  logic [1:0]        rx_sync_r;
  logic              rx_prev_r;
  logic              rx_line_s;
  logic              rx_fall_s;
  rx_state_e         rx_state_r;
  logic [DATA_W-1:0] rx_shift_r;
  logic [BCW-1:0]    rx_cnt_r;
  logic              rx_par_r;
  logic              rx_hold_r;
  logic [DATA_W-1:0] rx_data_r;
  logic              rx_vld_r;
  logic              rx_perr_r;
  logic              rx_ferr_r;
  logic              rx_go_s;
  logic              rx_tick_s;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_r <= 2'b11;
      rx_prev_r <= 1'b1;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
      rx_prev_r <= rx_sync_r[1];
    end
  end

  assign rx_line_s = rx_sync_r[1];
  assign rx_fall_s = rx_prev_r && !rx_line_s;
  assign rx_go_s   = (rx_state_r == RX_IDLE) && !rx_hold_r && rx_fall_s;

  uart_bit_timer #(.DIV(DIV), .HALF_START(DIV / 2)) u_rx_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (rx_go_s || rx_tick_s),
    .half  (rx_state_r == RX_IDLE),
    .en    (rx_state_r != RX_IDLE),
    .tick  (rx_tick_s)
  );

  // RX frame sequencer: samples mid-bit, publishes word and flags at the stop sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_r <= RX_IDLE;
      rx_shift_r <= {DATA_W{1'b0}};
      rx_cnt_r   <= {BCW{1'b0}};
      rx_par_r   <= 1'b0;
      rx_hold_r  <= 1'b0;
      rx_data_r  <= {DATA_W{1'b0}};
      rx_vld_r   <= 1'b0;
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_vld_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          // After a framing error the line must return high before re-arming.
          if (rx_hold_r) begin
            if (rx_line_s) begin
              rx_hold_r <= 1'b0;
            end
          end else if (rx_go_s) begin
            rx_state_r <= RX_START;
          end
        end
        RX_START: begin
          if (rx_tick_s) begin
            if (rx_line_s) begin
              rx_state_r <= RX_IDLE;
            end else begin
              rx_cnt_r   <= {BCW{1'b0}};
              rx_state_r <= RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (rx_tick_s) begin
            rx_shift_r <= {rx_line_s, rx_shift_r[DATA_W-1:1]};
            if (rx_cnt_r == LAST_BIT) begin
              rx_state_r <= HAS_PAR ? RX_PARITY : RX_STOP;
            end else begin
              rx_cnt_r <= rx_cnt_r + BCW'(1);
            end
          end
        end
        RX_PARITY: begin
          if (rx_tick_s) begin
            rx_par_r   <= rx_line_s;
            rx_state_r <= RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_tick_s) begin
            rx_vld_r   <= 1'b1;
            rx_data_r  <= rx_shift_r;
            rx_perr_r  <= HAS_PAR && (rx_par_r != par_calc(16'(rx_shift_r), PARITY));
            rx_ferr_r  <= !rx_line_s;
            rx_hold_r  <= !rx_line_s;
            rx_state_r <= RX_IDLE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data = rx_data_r;
  assign rx_vld  = rx_vld_r;
  assign rx_perr = rx_perr_r;
  assign rx_ferr = rx_ferr_r;

endmodule

// File: tb/tb_uart_xcvr.sv
// Self-checking bench for uart_xcvr at a 10-clock bit period. Three
// instances cover no parity (bench-driven rx), even parity (tx looped to rx)
// and odd parity (bench-driven rx). Expected TX line levels per cycle and
// expected RX words are queued when stimulus is driven and compared when
// the design produces them.
`timescale 1ns/1ps
module tb_uart_xcvr;

  typedef struct packed { logic tx; logic rdy; } tx_exp_t;
  typedef struct packed { logic [7:0] data; logic perr; logic ferr; } rx_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;

  logic [7:0] tx_data_a = 8'h00, tx_data_e = 8'h00, tx_data_o = 8'h00;
  logic tx_vld_a = 1'b0, tx_vld_e = 1'b0, tx_vld_o = 1'b0;
  logic tx_rdy_a, tx_rdy_e, tx_rdy_o;
  logic tx_a, tx_e, tx_o;
  logic rx_a = 1'b1, rx_b = 1'b1;
  logic [7:0] rx_data_a, rx_data_e, rx_data_o;
  logic rx_vld_a, rx_vld_e, rx_vld_o;
  logic rx_perr_a, rx_perr_e, rx_perr_o;
  logic rx_ferr_a, rx_ferr_e, rx_ferr_o;

  int checks = 0;
  int errors = 0;

  tx_exp_t q_tx[$];
  rx_exp_t q_rx_a[$], q_rx_e[$], q_rx_o[$];
  rx_exp_t exp_a, exp_e, exp_o;

  always #5 clk = ~clk;

  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_p0 (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_vld(tx_vld_a), .tx_rdy(tx_rdy_a),
    .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a), .rx_vld(rx_vld_a), .rx_perr(rx_perr_a),
    .rx_ferr(rx_ferr_a));

  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_even (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_e), .tx_vld(tx_vld_e), .tx_rdy(tx_rdy_e),
    .tx(tx_e), .rx(tx_e), .rx_data(rx_data_e), .rx_vld(rx_vld_e), .rx_perr(rx_perr_e),
    .rx_ferr(rx_ferr_e));

  uart_xcvr #(.CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data_o), .tx_vld(tx_vld_o), .tx_rdy(tx_rdy_o),
    .tx(tx_o), .rx(rx_b), .rx_data(rx_data_o), .rx_vld(rx_vld_o), .rx_perr(rx_perr_o),
    .rx_ferr(rx_ferr_o));

  // Reference parity from a ones count: odd mode makes the total odd.
  function automatic logic exp_par(input logic [7:0] d, input int mode);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += d[i] ? 1 : 0;
    if (mode == 1) return ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return ((ones % 2) == 1) ? 1'b1 : 1'b0;
  endfunction

  function automatic void push_cyc(input logic txv, input logic rdy, input int n);
    tx_exp_t t;
    t.tx = txv;
    t.rdy = rdy;
    for (int i = 0; i < n; i++) q_tx.push_back(t);
  endfunction

  // Expected per-cycle line level and ready for one frame, starting at the START bit.
  function automatic void push_frame(input logic [7:0] d, input int mode);
    push_cyc(1'b0, 1'b0, 10);
    for (int b = 0; b < 8; b++) push_cyc(d[b], 1'b0, 10);
    if (mode != 0) push_cyc(exp_par(d, mode), 1'b0, 10);
    push_cyc(1'b1, 1'b0, 10);
  endfunction

  function automatic rx_exp_t mk_rx(input logic [7:0] d, input logic perr, input logic ferr);
    rx_exp_t r;
    r.data = d;
    r.perr = perr;
    r.ferr = ferr;
    return r;
  endfunction

  task automatic set_rx(input bit line_b, input logic v);
    if (line_b) rx_b = v;
    else rx_a = v;
  endtask

  // Drive one serial frame, 10 clocks per bit, leaving the line at the stop level.
  task automatic inject(input bit line_b, input logic [7:0] d, input bit with_par,
                        input logic pbit, input logic stop_v);
    set_rx(line_b, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      set_rx(line_b, d[i]);
      repeat (10) @(posedge clk);
      #1;
    end
    if (with_par) begin
      set_rx(line_b, pbit);
      repeat (10) @(posedge clk);
      #1;
    end
    set_rx(line_b, stop_v);
    repeat (10) @(posedge clk);
    #1;
  endtask

  // RX scoreboards: every rx_vld pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rx_vld_a === 1'b1) begin
      checks++;
      if (q_rx_a.size() == 0) begin
        errors++;
        $display("FAIL rx_a_unexpected: got data=%h perr=%b ferr=%b, required no rx_vld",
                 rx_data_a, rx_perr_a, rx_ferr_a);
      end else begin
        exp_a = q_rx_a.pop_front();
        if ({rx_data_a, rx_perr_a, rx_ferr_a} !== exp_a) begin
          errors++;
          $display("FAIL rx_a_word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   rx_data_a, rx_perr_a, rx_ferr_a, exp_a.data, exp_a.perr, exp_a.ferr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rx_vld_e === 1'b1) begin
      checks++;
      if (q_rx_e.size() == 0) begin
        errors++;
        $display("FAIL rx_e_unexpected: got data=%h perr=%b ferr=%b, required no rx_vld",
                 rx_data_e, rx_perr_e, rx_ferr_e);
      end else begin
        exp_e = q_rx_e.pop_front();
        if ({rx_data_e, rx_perr_e, rx_ferr_e} !== exp_e) begin
          errors++;
          $display("FAIL rx_e_word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   rx_data_e, rx_perr_e, rx_ferr_e, exp_e.data, exp_e.perr, exp_e.ferr);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rx_vld_o === 1'b1) begin
      checks++;
      if (q_rx_o.size() == 0) begin
        errors++;
        $display("FAIL rx_o_unexpected: got data=%h perr=%b ferr=%b, required no rx_vld",
                 rx_data_o, rx_perr_o, rx_ferr_o);
      end else begin
        exp_o = q_rx_o.pop_front();
        if ({rx_data_o, rx_perr_o, rx_ferr_o} !== exp_o) begin
          errors++;
          $display("FAIL rx_o_word: got data=%h perr=%b ferr=%b, required data=%h perr=%b ferr=%b",
                   rx_data_o, rx_perr_o, rx_ferr_o, exp_o.data, exp_o.perr, exp_o.ferr);
        end
      end
    end
  end

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_a, tx_rdy_a, rx_data_a, rx_vld_a, rx_perr_a, rx_ferr_a} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_p0: got tx=%b rdy=%b data=%h vld=%b perr=%b ferr=%b, required 1 1 00 0 0 0",
               tx_a, tx_rdy_a, rx_data_a, rx_vld_a, rx_perr_a, rx_ferr_a);
    end
    checks++;
    if ({tx_e, tx_rdy_e, rx_data_e, rx_vld_e, rx_perr_e, rx_ferr_e} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_even: got tx=%b rdy=%b data=%h vld=%b perr=%b ferr=%b, required 1 1 00 0 0 0",
               tx_e, tx_rdy_e, rx_data_e, rx_vld_e, rx_perr_e, rx_ferr_e);
    end
    checks++;
    if ({tx_o, tx_rdy_o, rx_data_o, rx_vld_o, rx_perr_o, rx_ferr_o} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_odd: got tx=%b rdy=%b data=%h vld=%b perr=%b ferr=%b, required 1 1 00 0 0 0",
               tx_o, tx_rdy_o, rx_data_o, rx_vld_o, rx_perr_o, rx_ferr_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({tx_a, tx_rdy_a} !== 2'b11) begin
      errors++;
      $display("FAIL reset_release: got tx=%b rdy=%b, required 1 1", tx_a, tx_rdy_a);
    end
  endtask

  // 0xA5 without parity; a tx_vld burst while busy must be ignored.
  task automatic test_tx_format;
    tx_exp_t e;
    int i;
    push_frame(8'hA5, 0);
    push_cyc(1'b1, 1'b1, 20);
    @(posedge clk);
    #1 tx_data_a = 8'hA5;
    tx_vld_a = 1'b1;
    @(posedge clk);
    #1 tx_vld_a = 1'b0;
    tx_data_a = 8'hFF;
    i = 0;
    while (q_tx.size() > 0) begin
      @(negedge clk);
      if (i == 20) tx_vld_a = 1'b1;
      if (i == 30) tx_vld_a = 1'b0;
      e = q_tx.pop_front();
      checks++;
      if ({tx_a, tx_rdy_a} !== {e.tx, e.rdy}) begin
        errors++;
        $display("FAIL tx_a5 cycle %0d: got tx=%b rdy=%b, required tx=%b rdy=%b",
                 i, tx_a, tx_rdy_a, e.tx, e.rdy);
      end
      i++;
    end
  endtask

  // tx_vld held across a frame: the next START follows the handshake cycle directly.
  task automatic test_back_to_back;
    tx_exp_t e;
    int i;
    push_frame(8'h96, 0);
    push_cyc(1'b1, 1'b1, 1);
    push_frame(8'h3E, 0);
    push_cyc(1'b1, 1'b1, 5);
    @(posedge clk);
    #1 tx_data_a = 8'h96;
    tx_vld_a = 1'b1;
    @(posedge clk);
    #1 tx_data_a = 8'h3E;
    i = 0;
    while (q_tx.size() > 0) begin
      @(negedge clk);
      if (i == 101) tx_vld_a = 1'b0;
      e = q_tx.pop_front();
      checks++;
      if ({tx_a, tx_rdy_a} !== {e.tx, e.rdy}) begin
        errors++;
        $display("FAIL b2b cycle %0d: got tx=%b rdy=%b, required tx=%b rdy=%b",
                 i, tx_a, tx_rdy_a, e.tx, e.rdy);
      end
      i++;
    end
  endtask

  // Even parity 0x07 with tx looped back into rx.
  task automatic test_tx_even_loop;
    tx_exp_t e;
    int i;
    int n;
    push_frame(8'h07, 2);
    push_cyc(1'b1, 1'b1, 10);
    q_rx_e.push_back(mk_rx(8'h07, 1'b0, 1'b0));
    @(posedge clk);
    #1 tx_data_e = 8'h07;
    tx_vld_e = 1'b1;
    @(posedge clk);
    #1 tx_vld_e = 1'b0;
    i = 0;
    while (q_tx.size() > 0) begin
      @(negedge clk);
      e = q_tx.pop_front();
      checks++;
      if ({tx_e, tx_rdy_e} !== {e.tx, e.rdy}) begin
        errors++;
        $display("FAIL tx_even cycle %0d: got tx=%b rdy=%b, required tx=%b rdy=%b",
                 i, tx_e, tx_rdy_e, e.tx, e.rdy);
      end
      i++;
    end
    n = 0;
    while (q_rx_e.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_rx_e.size() != 0) begin
      errors++;
      $display("FAIL even_loop_timeout: got %0d words pending, required 0", q_rx_e.size());
    end
  endtask

  // Odd parity: one frame with the wrong parity bit, one with the right one.
  task automatic test_parity_error;
    int n;
    q_rx_o.push_back(mk_rx(8'h3C, 1'b1, 1'b0));
    inject(1'b1, 8'h3C, 1'b1, ~exp_par(8'h3C, 1), 1'b1);
    q_rx_o.push_back(mk_rx(8'h3C, 1'b0, 1'b0));
    inject(1'b1, 8'h3C, 1'b1, exp_par(8'h3C, 1), 1'b1);
    n = 0;
    while (q_rx_o.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_rx_o.size() != 0) begin
      errors++;
      $display("FAIL parity_timeout: got %0d words pending, required 0", q_rx_o.size());
    end
  endtask

  // Stop bit low, line held low afterwards: one ferr frame and nothing more.
  task automatic test_framing_error;
    int n;
    q_rx_a.push_back(mk_rx(8'h55, 1'b0, 1'b1));
    inject(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #1 rx_a = 1'b1;
    n = 0;
    while (q_rx_a.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_rx_a.size() != 0) begin
      errors++;
      $display("FAIL ferr_timeout: got %0d words pending, required 0", q_rx_a.size());
    end
    repeat (20) @(posedge clk);
    #1;
  endtask

  // Short low glitch must be rejected; a clean 0x81 frame follows.
  task automatic test_glitch;
    int n;
    rx_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx_a = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    q_rx_a.push_back(mk_rx(8'h81, 1'b0, 1'b0));
    inject(1'b0, 8'h81, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (q_rx_a.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q_rx_a.size() != 0) begin
      errors++;
      $display("FAIL glitch_timeout: got %0d words pending, required 0", q_rx_a.size());
    end
  endtask

  // Reset during data bit 3 with tx_vld held: line idles, then a full new frame.
  task automatic test_reset_midframe;
    tx_exp_t e;
    int i;
    @(posedge clk);
    #1 tx_data_a = 8'hC3;
    tx_vld_a = 1'b1;
    @(posedge clk);
    repeat (44) @(posedge clk);
    #1;
    checks++;
    if ({tx_a, tx_rdy_a} !== 2'b00) begin
      errors++;
      $display("FAIL midframe_bit3: got tx=%b rdy=%b, required tx=0 rdy=0", tx_a, tx_rdy_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_a, tx_rdy_a} !== 2'b11) begin
      errors++;
      $display("FAIL async_reset: got tx=%b rdy=%b, required tx=1 rdy=1", tx_a, tx_rdy_a);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({tx_a, tx_rdy_a, rx_vld_a} !== 3'b110) begin
        errors++;
        $display("FAIL in_reset %0d: got tx=%b rdy=%b vld=%b, required 1 1 0", k, tx_a, tx_rdy_a, rx_vld_a);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    push_frame(8'hC3, 0);
    push_cyc(1'b1, 1'b1, 5);
    @(negedge clk);
    checks++;
    if ({tx_a, tx_rdy_a} !== 2'b11) begin
      errors++;
      $display("FAIL post_release: got tx=%b rdy=%b, required tx=1 rdy=1", tx_a, tx_rdy_a);
    end
    @(posedge clk);
    #1 tx_vld_a = 1'b0;
    i = 0;
    while (q_tx.size() > 0) begin
      @(negedge clk);
      e = q_tx.pop_front();
      checks++;
      if ({tx_a, tx_rdy_a} !== {e.tx, e.rdy}) begin
        errors++;
        $display("FAIL restart cycle %0d: got tx=%b rdy=%b, required tx=%b rdy=%b",
                 i, tx_a, tx_rdy_a, e.tx, e.rdy);
      end
      i++;
    end
  endtask

  initial begin
    test_reset();
    test_tx_format();
    test_back_to_back();
    test_tx_even_loop();
    test_parity_error();
    test_framing_error();
    test_glitch();
    test_reset_midframe();
    repeat (20) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
